// File: rtl/nes_joy_pkg.sv
// nes_joy_pkg: shared constants for the NES joypad serializer.
// Button bit order, sequence lengths and Four Score signatures.
package nes_joy_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_JOY_LEN_STD = 8;
    localparam int NES_JOY_LEN_FS  = 24;

    // Signatures are stored in LSB-first shift order
    localparam logic [7:0] SIG_PORT0 = 8'h08;
    localparam logic [7:0] SIG_PORT1 = 8'h04;

    // Four Score read word: near pad, far pad, then signature
    function automatic logic [23:0] nes_joy_fs_word(
        input logic [7:0] i_near,
        input logic [7:0] i_far,
        input logic [7:0] i_sig
    );
        return {i_sig, i_far, i_near};
    endfunction

endpackage

// File: rtl/nes_joy_port.sv
// nes_joy_port: one controller port's load/shift/count channel.
// Shifts LSB-first on falling read edges; strobe reloads and wins.
module nes_joy_port
    import nes_joy_pkg::*;
#(
    parameter int W    = 8,
    parameter bit FILL = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_strobe,
    input  logic         i_read,
    input  logic         i_long,
    input  logic [W-1:0] i_load,
    output logic         o_data,
    output logic         o_exhausted
);

    localparam int CW = (W > NES_JOY_LEN_STD) ? 5 : 4;
    localparam logic [CW-1:0] LEN_STD = CW'(NES_JOY_LEN_STD);
    localparam logic [CW-1:0] LEN_FS  = CW'(NES_JOY_LEN_FS);

    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_prev;
    logic          r_long;
    logic          r_exh;

    logic          w_fall;
    logic          w_shift;
    logic [CW-1:0] w_len;
    logic [CW-1:0] w_cnt_nxt;

    assign w_len     = r_long ? LEN_FS : LEN_STD;
    assign w_fall    = r_prev & ~i_read;
    assign w_shift   = w_fall & ~i_strobe & (r_cnt != w_len);
    assign w_cnt_nxt = r_cnt + 1'b1;

    // Read edge tracker runs regardless of strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_read;
        end
    end

    // Reload while strobed, otherwise shift on falling read edges
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_long  <= 1'b0;
            r_exh   <= 1'b0;
        end else if (i_strobe) begin
            r_shift <= i_load;
            r_cnt   <= '0;
            r_long  <= i_long;
            r_exh   <= 1'b0;
        end else if (w_shift) begin
            r_shift <= {FILL, r_shift[W-1:1]};
            r_cnt   <= w_cnt_nxt;
            r_exh   <= (w_cnt_nxt == w_len);
        end
    end

    assign o_data      = r_shift[0];
    assign o_exhausted = r_exh;

endmodule

// File: rtl/nes_joypad_serializer.sv
// nes_joypad_serializer: dual-port NES controller serializer.
// Synchronizes pad inputs and builds each port's load word.
module nes_joypad_serializer
    import nes_joy_pkg::*;
#(
    parameter int C_pads      = 2,
    parameter bit C_fourscore = 1'b0,
    parameter bit C_fill      = 1'b1,
    parameter int C_sync      = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [C_pads*8-1:0] i_buttons,
    input  logic              i_fourscore,
    input  logic              i_strobe,
    input  logic [1:0]        i_read,
    output logic [1:0]        o_data,
    output logic [1:0]        o_exhausted
);

    localparam int NB = C_pads * 8;
    localparam int W  = C_fourscore ? NES_JOY_LEN_FS : NES_JOY_LEN_STD;
    localparam int NP = C_fourscore ? 4 : 2;
    localparam int AW = NP * 8;

    logic [NB-1:0] w_btn;
    logic [AW-1:0] w_all;
    logic          w_fs;

    if (C_sync == 0) begin : g_nosync
        assign w_btn = i_buttons;
    end else begin : g_sync
        logic [NB-1:0] r_sync [C_sync];

        // Multi-flop synchronizer for asynchronous button sources
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < C_sync; i++) begin
                    r_sync[i] <= '0;
                end
            end else begin
                r_sync[0] <= i_buttons;
                for (int i = 1; i < C_sync; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign w_btn = r_sync[C_sync-1];
    end

    // Absent pads read as all-released
    assign w_all = AW'(w_btn);
    assign w_fs  = C_fourscore & i_fourscore;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [W-1:0] w_load;

        if (C_fourscore) begin : g_fs
            assign w_load = w_fs
                ? nes_joy_fs_word(w_all[8*p +: 8],
                                  w_all[8*(p+2) +: 8],
                                  (p == 0) ? SIG_PORT0 : SIG_PORT1)
                : {{16{C_fill}}, w_all[8*p +: 8]};
        end else begin : g_std
            assign w_load = w_all[8*p +: 8];
        end

        nes_joy_port #(
            .W    (W),
            .FILL (C_fill)
        ) u_port (
            .clk         (clk),
            .resetn      (resetn),
            .i_strobe    (i_strobe),
            .i_read      (i_read[p]),
            .i_long      (w_fs),
            .i_load      (w_load),
            .o_data      (o_data[p]),
            .o_exhausted (o_exhausted[p])
        );
    end

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// tb_nes_joypad_serializer: directed bench with a sequence-level model.
// Three variants: Four Score fill 1, Four Score fill 0, standard.
module tb_nes_joypad_serializer;

    localparam int NI = 3;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] btn    = '0;
    logic        fs     = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  rd     = '0;

    logic [1:0] d_a, e_a, d_b, e_b, d_c, e_c;
    logic [1:0] a_data [NI];
    logic [1:0] a_exh  [NI];

    int n_pass = 0;
    int n_tot  = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    nes_joypad_serializer #(
        .C_pads(4), .C_fourscore(1'b1), .C_fill(1'b1), .C_sync(2)
    ) dut_a (
        .clk(clk), .resetn(resetn), .i_buttons(btn),
        .i_fourscore(fs), .i_strobe(strobe), .i_read(rd),
        .o_data(d_a), .o_exhausted(e_a)
    );

    nes_joypad_serializer #(
        .C_pads(4), .C_fourscore(1'b1), .C_fill(1'b0), .C_sync(2)
    ) dut_b (
        .clk(clk), .resetn(resetn), .i_buttons(btn),
        .i_fourscore(fs), .i_strobe(strobe), .i_read(rd),
        .o_data(d_b), .o_exhausted(e_b)
    );

    nes_joypad_serializer #(
        .C_pads(2), .C_fourscore(1'b0), .C_fill(1'b1), .C_sync(2)
    ) dut_c (
        .clk(clk), .resetn(resetn), .i_buttons(btn[15:0]),
        .i_fourscore(fs), .i_strobe(strobe), .i_read(rd),
        .o_data(d_c), .o_exhausted(e_c)
    );

    assign a_data[0] = d_a;
    assign a_data[1] = d_b;
    assign a_data[2] = d_c;
    assign a_exh[0]  = e_a;
    assign a_exh[1]  = e_b;
    assign a_exh[2]  = e_c;

    // Model: per port a latched bit sequence and a read index
    bit        m_fshw [NI] = '{1'b1, 1'b1, 1'b0};
    bit        m_fill [NI] = '{1'b1, 1'b0, 1'b1};
    bit [31:0] m_h0, m_h1, m_used;
    bit [1:0]  m_prev;
    bit [31:0] m_seq [NI][2];
    int        m_len [NI][2];
    int        m_idx [NI][2];
    bit        m_ld  [NI][2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic exp_d(int i, int p);
        if (!m_ld[i][p]) return 1'b0;
        if (m_idx[i][p] < m_len[i][p]) return m_seq[i][p][m_idx[i][p]];
        return m_fill[i];
    endfunction

    function automatic logic exp_e(int i, int p);
        return m_ld[i][p] && (m_idx[i][p] == m_len[i][p]);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_h0   = '0;
            m_h1   = '0;
            m_prev = '0;
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < 2; p++) m_ld[i][p] = 1'b0;
        end else begin
            m_used = m_h1;
            m_h1   = m_h0;
            m_h0   = btn;
            for (int i = 0; i < NI; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (strobe) begin
                        if (m_fshw[i] && fs) begin
                            m_seq[i][p] = {8'h00,
                                           (p == 0) ? 8'h08 : 8'h04,
                                           m_used[8*(p+2) +: 8],
                                           m_used[8*p +: 8]};
                            m_len[i][p] = 24;
                        end else begin
                            m_seq[i][p] = {24'h0, m_used[8*p +: 8]};
                            m_len[i][p] = 8;
                        end
                        m_idx[i][p] = 0;
                        m_ld[i][p]  = 1'b1;
                    end else if (m_prev[p] && !rd[p] &&
                                 m_idx[i][p] < m_len[i][p]) begin
                        m_idx[i][p]++;
                    end
                end
            end
            m_prev = rd;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < NI; i++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("cyc_data i%0d p%0d", i, p),
                        32'(a_data[i][p]), 32'(exp_d(i, p)));
                    chk($sformatf("cyc_exh i%0d p%0d", i, p),
                        32'(a_exh[i][p]), 32'(exp_e(i, p)));
                end
            end
        end
    end

    task automatic latch();
        repeat (3) step();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] m);
        rd = m;
        step();
        rd = 2'b00;
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [9:0]  bits1;
    logic [23:0] w0, w1;
    logic [5:0]  fa, fb;

    initial begin
        #1 resetn = 1'b0;
        run = 1'b1;
        #1;
        chk("reset_data", 32'({d_a, d_b, d_c}), 32'h0);
        chk("reset_exh", 32'({e_a, e_b, e_c}), 32'h0);
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Normal mode, pad0 = 0x81
        btn = 32'h0000_5A81;
        latch();
        for (int k = 0; k < 10; k++) begin
            bits1[k] = d_a[0];
            pulse(2'b01);
            if (k == 6) chk("t1_exh_edge7", 32'(e_a[0]), 32'h0);
            if (k == 7) chk("t1_exh_edge8", 32'(e_a[0]), 32'h1);
        end
        chk("t1_seq", 32'(bits1), 32'h381);

        // Four Score, pads 0..3 = 00,00,02,01
        fs  = 1'b1;
        btn = 32'h0102_0000;
        latch();
        for (int k = 0; k < 24; k++) begin
            w0[k] = d_a[0];
            w1[k] = d_a[1];
            pulse(2'b11);
        end
        chk("t2_port0_word", 32'(w0), 32'h080200);
        chk("t2_port1_word", 32'(w1), 32'h040100);
        chk("t2_b_read10", 32'(w0[9]), 32'h1);
        chk("t2_sig_read20", 32'(w0[19]), 32'h1);
        chk("t2_p1_a_read9", 32'(w1[8]), 32'h1);
        chk("t2_p1_sig_read19", 32'(w1[18]), 32'h1);
        chk("t2_exh", 32'(e_a), 32'h3);

        // Past exhaustion: fill 1 vs fill 0
        for (int k = 0; k < 6; k++) begin
            fa[k] = d_a[0];
            fb[k] = d_b[0];
            pulse(2'b11);
        end
        chk("t3_fill1", 32'(fa), 32'h3F);
        chk("t3_fill0", 32'(fb), 32'h00);
        chk("t3_exh_hold", 32'({e_a, e_b}), 32'hF);

        // Strobe held: buttons flow through, reads ignored
        fs  = 1'b0;
        btn = 32'h0;
        latch();
        strobe = 1'b1;
        repeat (3) step();
        btn = 32'h0000_0001;
        for (int s = 1; s <= 3; s++) begin
            rd[0] = ~rd[0];
            step();
            if (s == 2) chk("t4_lat_c2", 32'(d_a[0]), 32'h0);
            if (s == 3) chk("t4_lat_c3", 32'(d_a[0]), 32'h1);
        end
        chk("t4_exh", 32'(e_a[0]), 32'h0);
        rd = 2'b00;
        step();
        strobe = 1'b0;
        step();
        chk("t4_release", 32'(d_a[0]), 32'h1);

        // Strobe beats a simultaneous read edge
        btn = 32'h0000_E1FE;
        latch();
        rd = 2'b11;
        step();
        rd = 2'b00;
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        chk("t5_no_shift", 32'(d_a), 32'h2);
        chk("t5_no_shift_exh", 32'(e_a), 32'h0);
        repeat (5) pulse(2'b11);
        chk("t5_after5", 32'(d_a), 32'h3);

        // Reset mid-sequence
        resetn = 1'b0;
        #1;
        chk("t5_rst_data", 32'({d_a, d_b, d_c}), 32'h0);
        chk("t5_rst_exh", 32'({e_a, e_b, e_c}), 32'h0);
        step();
        step();
        resetn = 1'b1;
        latch();
        chk("t5_restart0", 32'(d_a), 32'h2);
        pulse(2'b11);
        chk("t5_restart1", 32'(d_a), 32'h1);

        step();
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
